// File: rtl/usb_ep_fifo_bank.sv
// ============================================================================
// Module   : usb_ep_fifo_bank
// Purpose  : Parametrised USB endpoint buffer bank with packet-level
//            commit/rollback between the SIE and the application.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_ep_fifo_bank #(
    parameter int                NUM_EP = 3,
    parameter int                WIDTH  = 8,
    parameter int                DEPTH  = 16,
    parameter logic [NUM_EP-1:0] EP_IN  = 3'b101,
    localparam int               EPW    = (NUM_EP > 1) ? $clog2(NUM_EP) : 1,
    localparam int               AW     = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [EPW-1:0]             sie_ep,
    input  logic                       sie_wr,
    input  logic [WIDTH-1:0]           sie_wdata,
    input  logic                       sie_rd,
    output logic [WIDTH-1:0]           sie_rdata,
    input  logic                       sie_commit,
    input  logic                       sie_rollback,
    output logic                       sie_empty,
    output logic                       sie_full,
    input  logic [NUM_EP-1:0]          usr_wr,
    input  logic [NUM_EP*WIDTH-1:0]    usr_wdata,
    input  logic [NUM_EP-1:0]          usr_rd,
    output logic [NUM_EP*WIDTH-1:0]    usr_rdata,
    output logic [NUM_EP-1:0]          usr_empty,
    output logic [NUM_EP-1:0]          usr_full,
    output logic [NUM_EP*(AW+1)-1:0]   usr_level,
    input  logic [NUM_EP-1:0]          usr_sclr
);

    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

    logic [NUM_EP-1:0] w_ep_sie_empty;
    logic [NUM_EP-1:0] w_ep_sie_full;
    logic [NUM_EP-1:0] w_ep_sie_rd;
    logic [WIDTH-1:0]  w_ep_rd_word [NUM_EP];

    logic [WIDTH-1:0]  r_sie_rdata;
    logic [WIDTH-1:0]  w_sie_rd_word;
    logic              w_sie_rd_any;
    logic              w_sie_empty;
    logic              w_sie_full;

    for (genvar gi = 0; gi < NUM_EP; gi++) begin : g_ep
        localparam bit c_is_in = EP_IN[gi];

        logic [AW:0]      r_wp, r_wc, r_rp, r_rc;
        logic [WIDTH-1:0] r_mem [DEPTH];
        logic [WIDTH-1:0] r_usr_rdata;

        logic             w_sel, w_clr;
        logic             w_wr_req, w_rd_req, w_wr_ok, w_rd_ok;
        logic             w_full, w_empty, w_commit, w_rollback;
        logic [AW:0]      w_used, w_level, w_wp_inc, w_rp_inc;
        logic [WIDTH-1:0] w_wdata;

        assign w_sel      = (sie_ep == EPW'(gi));
        assign w_clr      = usr_sclr[gi];
        assign w_wr_req   = c_is_in ? usr_wr[gi] : (w_sel & sie_wr);
        assign w_rd_req   = c_is_in ? (w_sel & sie_rd) : usr_rd[gi];
        assign w_wdata    = c_is_in ? usr_wdata[gi*WIDTH +: WIDTH] : sie_wdata;

        // Space is freed only by the committed read pointer on IN endpoints
        // (un-ACKed data may be retransmitted), by the live read pointer on OUT.
        assign w_used     = c_is_in ? (r_wp - r_rc) : (r_wp - r_rp);
        assign w_level    = c_is_in ? (r_wp - r_rc) : (r_wc - r_rp);
        assign w_full     = (w_used == c_depth);
        assign w_empty    = c_is_in ? (r_rp == r_wp) : (r_rp == r_wc);

        assign w_wr_ok    = w_wr_req & ~w_full  & ~w_clr;
        assign w_rd_ok    = w_rd_req & ~w_empty & ~w_clr;
        assign w_wp_inc   = r_wp + {{AW{1'b0}}, w_wr_ok};
        assign w_rp_inc   = r_rp + {{AW{1'b0}}, w_rd_ok};
        assign w_rollback = w_sel & sie_rollback;
        assign w_commit   = w_sel & sie_commit & ~sie_rollback;

        always_ff @(posedge clk) begin
            if (reset || w_clr) begin
                r_wp <= '0;
                r_wc <= '0;
                r_rp <= '0;
                r_rc <= '0;
            end else if (c_is_in) begin
                r_wp <= w_wp_inc;
                r_wc <= w_wp_inc;
                r_rp <= w_rollback ? r_rc : w_rp_inc;
                if (w_commit) begin
                    r_rc <= w_rp_inc;
                end
            end else begin
                r_wp <= w_rollback ? r_wc : w_wp_inc;
                if (w_commit) begin
                    r_wc <= w_wp_inc;
                end
                r_rp <= w_rp_inc;
                r_rc <= w_rp_inc;
            end
        end

        always_ff @(posedge clk) begin
            if (w_wr_ok) begin
                r_mem[r_wp[AW-1:0]] <= w_wdata;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_usr_rdata <= '0;
            end else if (!c_is_in && w_rd_ok) begin
                r_usr_rdata <= r_mem[r_rp[AW-1:0]];
            end
        end

        assign usr_rdata[gi*WIDTH +: WIDTH]  = r_usr_rdata;
        assign usr_empty[gi]                 = c_is_in ? 1'b0 : w_empty;
        assign usr_full[gi]                  = c_is_in ? w_full : 1'b0;
        assign usr_level[gi*(AW+1) +: AW+1]  = w_level;

        assign w_ep_sie_empty[gi] = c_is_in ? w_empty : 1'b1;
        assign w_ep_sie_full[gi]  = c_is_in ? 1'b1 : w_full;
        assign w_ep_sie_rd[gi]    = c_is_in & w_rd_ok;
        assign w_ep_rd_word[gi]   = r_mem[r_rp[AW-1:0]];
    end

    // Out-of-range endpoint numbers match no entry and fall to empty=full=1.
    always_comb begin
        w_sie_empty   = 1'b1;
        w_sie_full    = 1'b1;
        w_sie_rd_any  = 1'b0;
        w_sie_rd_word = '0;
        for (int i = 0; i < NUM_EP; i++) begin
            if (sie_ep == EPW'(i)) begin
                w_sie_empty = w_ep_sie_empty[i];
                w_sie_full  = w_ep_sie_full[i];
            end
            if (w_ep_sie_rd[i]) begin
                w_sie_rd_any  = 1'b1;
                w_sie_rd_word = w_ep_rd_word[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sie_rdata <= '0;
        end else if (w_sie_rd_any) begin
            r_sie_rdata <= w_sie_rd_word;
        end
    end

    assign sie_rdata = r_sie_rdata;
    assign sie_empty = w_sie_empty;
    assign sie_full  = w_sie_full;

endmodule

`default_nettype wire

// File: tb/tb_usb_ep_fifo_bank.sv
// ============================================================================
// Module   : tb_usb_ep_fifo_bank
// Purpose  : Directed self-checking bench for usb_ep_fifo_bank
//            (ep0 and ep1 OUT, ep2 IN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_usb_ep_fifo_bank;

    localparam int NUM_EP = 3;
    localparam int WIDTH  = 8;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;
    localparam int EPW    = 2;

    logic                      clk;
    logic                      reset;
    logic [EPW-1:0]            sie_ep;
    logic                      sie_wr;
    logic [WIDTH-1:0]          sie_wdata;
    logic                      sie_rd;
    logic [WIDTH-1:0]          sie_rdata;
    logic                      sie_commit;
    logic                      sie_rollback;
    logic                      sie_empty;
    logic                      sie_full;
    logic [NUM_EP-1:0]         usr_wr;
    logic [NUM_EP*WIDTH-1:0]   usr_wdata;
    logic [NUM_EP-1:0]         usr_rd;
    logic [NUM_EP*WIDTH-1:0]   usr_rdata;
    logic [NUM_EP-1:0]         usr_empty;
    logic [NUM_EP-1:0]         usr_full;
    logic [NUM_EP*(AW+1)-1:0]  usr_level;
    logic [NUM_EP-1:0]         usr_sclr;

    int n_chk  = 0;
    int n_fail = 0;

    usb_ep_fifo_bank #(
        .NUM_EP (NUM_EP),
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .EP_IN  (3'b100)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sie_ep       (sie_ep),
        .sie_wr       (sie_wr),
        .sie_wdata    (sie_wdata),
        .sie_rd       (sie_rd),
        .sie_rdata    (sie_rdata),
        .sie_commit   (sie_commit),
        .sie_rollback (sie_rollback),
        .sie_empty    (sie_empty),
        .sie_full     (sie_full),
        .usr_wr       (usr_wr),
        .usr_wdata    (usr_wdata),
        .usr_rd       (usr_rd),
        .usr_rdata    (usr_rdata),
        .usr_empty    (usr_empty),
        .usr_full     (usr_full),
        .usr_level    (usr_level),
        .usr_sclr     (usr_sclr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [AW:0] lvl(input int ep);
        return usr_level[ep*(AW+1) +: AW+1];
    endfunction

    function automatic logic [WIDTH-1:0] urd(input int ep);
        return usr_rdata[ep*WIDTH +: WIDTH];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sie_write(input logic [EPW-1:0] ep, input logic [7:0] d);
        sie_ep = ep; sie_wr = 1'b1; sie_wdata = d;
        tick();
        sie_wr = 1'b0;
    endtask

    task automatic sie_cmd(input logic [EPW-1:0] ep, input logic c, input logic r);
        sie_ep = ep; sie_commit = c; sie_rollback = r;
        tick();
        sie_commit = 1'b0; sie_rollback = 1'b0;
    endtask

    task automatic usr_read_chk(input int ep, input logic [7:0] exp, input string tag);
        usr_rd[ep] = 1'b1;
        tick();
        usr_rd[ep] = 1'b0;
        chk(tag, 32'(urd(ep)), 32'(exp));
    endtask

    task automatic sie_read_chk(input logic [EPW-1:0] ep, input logic [7:0] exp, input string tag);
        sie_ep = ep; sie_rd = 1'b1;
        tick();
        sie_rd = 1'b0;
        chk(tag, 32'(sie_rdata), 32'(exp));
    endtask

    task automatic usr_write(input int ep, input logic [7:0] d);
        usr_wr[ep] = 1'b1; usr_wdata[ep*WIDTH +: WIDTH] = d;
        tick();
        usr_wr[ep] = 1'b0;
    endtask

    initial begin
        reset = 1'b1; sie_ep = '0; sie_wr = 1'b0; sie_wdata = '0; sie_rd = 1'b0;
        sie_commit = 1'b0; sie_rollback = 1'b0; usr_wr = '0; usr_wdata = '0;
        usr_rd = '0; usr_sclr = '0;
        tick(); tick();
        reset = 1'b0;

        // Reset state (ep0/ep1 OUT report empty, ep2 IN never reports empty)
        chk("rst_sie_rdata", 32'(sie_rdata), 32'h0);
        chk("rst_usr_rdata", 32'(usr_rdata), 32'h0);
        chk("rst_usr_empty", 32'(usr_empty), 32'b011);
        chk("rst_usr_full",  32'(usr_full),  32'h0);
        chk("rst_usr_level", 32'(usr_level), 32'h0);
        chk("rst_sie_empty", 32'(sie_empty), 32'h1);
        chk("rst_sie_full",  32'(sie_full),  32'h0);

        // OUT ep0: data hidden until commit
        for (int k = 0; k < 8; k++) begin
            sie_write(0, 8'(8'h10 + k));
            chk("out_hidden_empty", 32'(usr_empty[0]), 32'h1);
            chk("out_hidden_level", 32'(lvl(0)), 32'h0);
        end
        chk("out_sie_empty", 32'(sie_empty), 32'h1);
        sie_cmd(0, 1'b1, 1'b0);
        chk("out_commit_level", 32'(lvl(0)), 32'd8);
        chk("out_commit_empty", 32'(usr_empty[0]), 32'h0);
        for (int k = 0; k < 8; k++) usr_read_chk(0, 8'(8'h10 + k), "out_rd_data");
        chk("out_drained_empty", 32'(usr_empty[0]), 32'h1);
        usr_read_chk(0, 8'h17, "out_rd_empty_hold");
        usr_write(0, 8'hEE);
        chk("wrong_side_usr_wr", 32'(lvl(0)), 32'h0);

        // OUT rollback: 4 committed, 5 speculative discarded
        for (int k = 0; k < 4; k++) sie_write(0, 8'(8'h20 + k));
        sie_cmd(0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) sie_write(0, 8'(8'h30 + k));
        sie_cmd(0, 1'b0, 1'b1);
        chk("out_rb_level", 32'(lvl(0)), 32'd4);
        sie_write(0, 8'h40);
        sie_cmd(0, 1'b1, 1'b0);
        chk("out_rb_level2", 32'(lvl(0)), 32'd5);
        for (int k = 0; k < 4; k++) usr_read_chk(0, 8'(8'h20 + k), "out_rb_data");
        usr_read_chk(0, 8'h40, "out_rb_next");

        // Same-cycle write + rollback discards the byte
        sie_write(0, 8'h50);
        sie_cmd(0, 1'b1, 1'b0);
        sie_ep = 0; sie_wr = 1'b1; sie_wdata = 8'h51; sie_rollback = 1'b1;
        tick();
        sie_wr = 1'b0; sie_rollback = 1'b0;
        sie_cmd(0, 1'b1, 1'b0);
        chk("wr_rb_level", 32'(lvl(0)), 32'd1);
        usr_read_chk(0, 8'h50, "wr_rb_data");

        // Commit + rollback together: rollback wins
        sie_write(0, 8'h60);
        sie_cmd(0, 1'b1, 1'b1);
        chk("cm_rb_level", 32'(lvl(0)), 32'd0);
        sie_cmd(0, 1'b1, 1'b0);
        chk("cm_rb_level2", 32'(lvl(0)), 32'd0);

        // Same-cycle write + commit includes the byte
        sie_ep = 0; sie_wr = 1'b1; sie_wdata = 8'h61; sie_commit = 1'b1;
        tick();
        sie_wr = 1'b0; sie_commit = 1'b0;
        chk("wr_cm_level", 32'(lvl(0)), 32'd1);
        usr_read_chk(0, 8'h61, "wr_cm_data");

        // Full: 17th write dropped
        for (int k = 0; k < 17; k++) begin
            sie_write(0, 8'(8'h80 + k));
            if (k == 14) chk("full_not_yet", 32'(sie_full), 32'h0);
        end
        chk("full_sie_full", 32'(sie_full), 32'h1);
        sie_cmd(0, 1'b1, 1'b0);
        chk("full_level", 32'(lvl(0)), 32'd16);
        chk("full_usr_full_out", 32'(usr_full[0]), 32'h0);
        for (int k = 0; k < 16; k++) usr_read_chk(0, 8'(8'h80 + k), "full_data");
        chk("full_drained", 32'(usr_empty[0]), 32'h1);

        // Wrap: 40 rounds of 3 bytes
        for (int it = 0; it < 40; it++) begin
            for (int j = 0; j < 3; j++) sie_write(0, 8'(it*3 + j + 1));
            sie_cmd(0, 1'b1, 1'b0);
            chk("wrap_level", 32'(lvl(0)), 32'd3);
            for (int j = 0; j < 3; j++) usr_read_chk(0, 8'(it*3 + j + 1), "wrap_data");
        end

        // IN ep2
        for (int k = 0; k < 16; k++) usr_write(2, 8'(8'hA0 + k));
        chk("in_usr_full", 32'(usr_full[2]), 32'h1);
        chk("in_level16", 32'(lvl(2)), 32'd16);
        usr_write(2, 8'hEE);
        chk("in_full_drop", 32'(lvl(2)), 32'd16);
        sie_ep = 2;
        #1;
        chk("in_sie_full", 32'(sie_full), 32'h1);
        chk("in_sie_empty", 32'(sie_empty), 32'h0);
        for (int k = 0; k < 8; k++) sie_read_chk(2, 8'(8'hA0 + k), "in_rd1");
        sie_cmd(2, 1'b0, 1'b1);
        chk("in_rb_full", 32'(usr_full[2]), 32'h1);
        for (int k = 0; k < 8; k++) sie_read_chk(2, 8'(8'hA0 + k), "in_rd2");
        sie_cmd(2, 1'b1, 1'b0);
        chk("in_cm_full", 32'(usr_full[2]), 32'h0);
        chk("in_cm_level", 32'(lvl(2)), 32'd8);

        // sclr on ep2 mid-transaction while ep0 holds data
        for (int k = 0; k < 2; k++) sie_write(0, 8'(8'hC0 + k));
        sie_cmd(0, 1'b1, 1'b0);
        sie_write(0, 8'hC2);
        for (int k = 0; k < 3; k++) sie_read_chk(2, 8'(8'hA8 + k), "in_rd3");
        usr_sclr[2] = 1'b1;
        tick();
        usr_sclr[2] = 1'b0;
        sie_ep = 2;
        #1;
        chk("sclr_level2", 32'(lvl(2)), 32'd0);
        chk("sclr_sie_empty", 32'(sie_empty), 32'h1);
        chk("sclr_usr_full", 32'(usr_full[2]), 32'h0);
        chk("sclr_ep0_level", 32'(lvl(0)), 32'd2);
        sie_cmd(0, 1'b1, 1'b0);
        chk("sclr_ep0_spec", 32'(lvl(0)), 32'd3);
        for (int k = 0; k < 3; k++) usr_read_chk(0, 8'(8'hC0 + k), "sclr_ep0_data");

        // Out-of-range endpoint
        sie_write(3, 8'h99);
        chk("oor_empty", 32'(sie_empty), 32'h1);
        chk("oor_full", 32'(sie_full), 32'h1);
        chk("oor_no_effect", 32'(usr_level), 32'h0);

        // Reset mid-packet
        sie_write(0, 8'hD0);
        usr_write(2, 8'hD1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sie_ep = 0;
        #1;
        chk("mrst_usr_rdata", 32'(usr_rdata), 32'h0);
        chk("mrst_sie_rdata", 32'(sie_rdata), 32'h0);
        chk("mrst_level", 32'(usr_level), 32'h0);
        chk("mrst_empty", 32'(usr_empty), 32'b011);
        chk("mrst_full", 32'(usr_full), 32'h0);
        chk("mrst_sie_empty", 32'(sie_empty), 32'h1);
        chk("mrst_sie_full", 32'(sie_full), 32'h0);
        sie_cmd(0, 1'b1, 1'b0);
        chk("mrst_lost", 32'(lvl(0)), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
